// File: rtl/lfsr_gen.sv
// WIDTH-bit Fibonacci/Galois LFSR with runtime seed load, all-zero lock-up recovery,
// and in-system period measurement so a tap mask can be checked against its expected cycle length.
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
    $error("lfsr_gen: WIDTH must lie in 2..32");
  end

  // An all-zero SEED would make the recovery path re-enter the lock-up state.
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be non-zero");
  end

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_wrap;
  logic             r_lockup;

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic             w_seed_zero;
  logic             w_state_zero;
  logic             w_cnt_sat;
  logic             w_hit_start;

  if (GALOIS) begin : g_galois
    assign w_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    assign bit_out = r_lfsr[0];
  end else begin : g_fibonacci
    assign w_next  = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign bit_out = r_lfsr[WIDTH-1];
  end

  assign w_seed_zero  = (seed_in == '0);
  assign w_load_val   = w_seed_zero ? SEED : seed_in;
  assign w_state_zero = (r_lfsr == '0);
  assign w_cnt_sat    = &r_step_cnt;
  assign w_hit_start  = (w_next == r_start);

  // A saturated counter means the start state was never revisited, so its count is not a period.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_lfsr     <= SEED;
      r_start    <= SEED;
      r_step_cnt <= '0;
      r_period   <= '0;
      r_wrap     <= 1'b0;
      r_lockup   <= 1'b0;
    end else begin
      r_wrap   <= 1'b0;
      r_lockup <= 1'b0;
      if (load) begin
        r_lfsr     <= w_load_val;
        r_start    <= w_load_val;
        r_step_cnt <= '0;
        r_lockup   <= w_seed_zero;
      end else if (en) begin
        if (w_state_zero) begin
          r_lfsr     <= SEED;
          r_start    <= SEED;
          r_step_cnt <= '0;
          r_lockup   <= 1'b1;
        end else begin
          r_lfsr <= w_next;
          if (w_hit_start) begin
            r_wrap     <= 1'b1;
            r_step_cnt <= '0;
            if (!w_cnt_sat) begin
              r_period <= r_step_cnt + 1'b1;
            end
          end else if (!w_cnt_sat) begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign lfsr   = r_lfsr;
  assign wrap   = r_wrap;
  assign lockup = r_lockup;
  assign period = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci and Galois sequences, seed load, zero-seed substitution,
// zero-state recovery with a non-maximal mask, mid-run reset and enable gaps.
module tb_lfsr_gen;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       load;
    logic [3:0] seed;
  } ctrl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_t c_f, c_g, c_n;

  logic [3:0] f_lfsr, f_period, g_lfsr, g_period, n_lfsr, n_period;
  logic       f_bit, f_wrap, f_lock, g_bit, g_wrap, g_lock, n_bit, n_wrap, n_lock;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .GALOIS(1'b0)) u_fib (
    .clk(clk), .rst(c_f.rst), .en(c_f.en), .load(c_f.load), .seed_in(c_f.seed),
    .lfsr(f_lfsr), .bit_out(f_bit), .wrap(f_wrap), .lockup(f_lock), .period(f_period)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .GALOIS(1'b1)) u_gal (
    .clk(clk), .rst(c_g.rst), .en(c_g.en), .load(c_g.load), .seed_in(c_g.seed),
    .lfsr(g_lfsr), .bit_out(g_bit), .wrap(g_wrap), .lockup(g_lock), .period(g_period)
  );

  // Taps on bit 0 only: from seed 2 the state shifts out to zero, and after recovery it sticks at F.
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0001), .SEED(4'h1), .GALOIS(1'b0)) u_nm (
    .clk(clk), .rst(c_n.rst), .en(c_n.en), .load(c_n.load), .seed_in(c_n.seed),
    .lfsr(n_lfsr), .bit_out(n_bit), .wrap(n_wrap), .lockup(n_lock), .period(n_period)
  );

  logic [3:0] fib_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                               4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] gal_seq [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                               4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    c_f = '{rst: 1'b1, en: 1'b0, load: 1'b0, seed: 4'h0};
    c_g = c_f;
    c_n = c_f;
    tick();
    tick();

    check("rst_f_lfsr",   f_lfsr,   4'h1);
    check("rst_f_period", f_period, 4'h0);
    check("rst_f_wrap",   f_wrap,   1'b0);
    check("rst_f_lock",   f_lock,   1'b0);
    check("rst_f_bit",    f_bit,    1'b0);
    check("rst_g_lfsr",   g_lfsr,   4'h1);
    check("rst_g_bit",    g_bit,    1'b1);
    check("rst_n_lfsr",   n_lfsr,   4'h1);

    // Fibonacci and Galois stepping side by side from reset.
    c_f.rst = 1'b0; c_g.rst = 1'b0; c_n.rst = 1'b0;
    c_f.en  = 1'b1; c_g.en  = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("fib_lfsr_%0d", k + 1), f_lfsr, fib_seq[k]);
      check($sformatf("fib_wrap_%0d", k + 1), f_wrap, (k == 14));
      check($sformatf("gal_lfsr_%0d", k + 1), g_lfsr, gal_seq[k]);
      check($sformatf("gal_wrap_%0d", k + 1), g_wrap, (k == 14));
      if (k == 2) check("fib_bit_at_9", f_bit, 1'b1);
      if (k == 0) check("gal_bit_at_c", g_bit, 1'b0);
    end
    check("fib_period", f_period, 4'd15);
    check("gal_period", g_period, 4'd15);
    check("fib_lock_quiet", f_lock, 1'b0);

    c_f.en = 1'b0; c_g.en = 1'b0;
    tick();
    check("fib_hold_lfsr", f_lfsr, 4'h1);
    check("fib_hold_wrap", f_wrap, 1'b0);
    check("gal_hold_lfsr", g_lfsr, 4'h1);
    check("gal_hold_wrap", g_wrap, 1'b0);
    check("gal_hold_period", g_period, 4'd15);

    // Load wins over a step on the same edge.
    c_f.load = 1'b1; c_f.seed = 4'h9; c_f.en = 1'b1;
    tick();
    check("load9_lfsr",   f_lfsr,   4'h9);
    check("load9_wrap",   f_wrap,   1'b0);
    check("load9_lock",   f_lock,   1'b0);
    check("load9_period", f_period, 4'd15);
    check("load9_bit",    f_bit,    1'b1);
    c_f.load = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("from9_lfsr_%0d", k + 1), f_lfsr, fib_seq[(k + 3) % 15]);
      check($sformatf("from9_wrap_%0d", k + 1), f_wrap, (k == 14));
    end
    check("from9_period", f_period, 4'd15);

    // Zero seed is replaced by SEED and flagged.
    c_f.load = 1'b1; c_f.seed = 4'h0;
    tick();
    check("load0_lfsr",   f_lfsr,   4'h1);
    check("load0_lock",   f_lock,   1'b1);
    check("load0_wrap",   f_wrap,   1'b0);
    check("load0_period", f_period, 4'd15);
    c_f.load = 1'b0;
    tick();
    check("load0_next_lfsr", f_lfsr, 4'h2);
    check("load0_next_lock", f_lock, 1'b0);

    // Continue to step 7, then reset mid-run.
    for (int k = 1; k < 7; k++) begin
      tick();
      check($sformatf("pre_rst_lfsr_%0d", k + 1), f_lfsr, fib_seq[k]);
    end
    c_f.rst = 1'b1;
    tick();
    check("midrst_lfsr",   f_lfsr,   4'h1);
    check("midrst_period", f_period, 4'h0);
    check("midrst_wrap",   f_wrap,   1'b0);
    c_f.rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("post_rst_lfsr_%0d", k + 1), f_lfsr, fib_seq[k]);
    end
    c_f.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("gap_lfsr_%0d", k), f_lfsr, 4'h6);
      check($sformatf("gap_wrap_%0d", k), f_wrap, 1'b0);
    end
    c_f.en = 1'b1;
    for (int k = 5; k < 15; k++) begin
      tick();
      check($sformatf("resume_lfsr_%0d", k + 1), f_lfsr, fib_seq[k]);
      check($sformatf("resume_wrap_%0d", k + 1), f_wrap, (k == 14));
    end
    check("resume_period", f_period, 4'd15);
    c_f.en = 1'b0;

    // Non-maximal mask: fall into zero, recover, then lock at F without wrapping.
    c_n.load = 1'b1; c_n.seed = 4'h2;
    tick();
    check("nm_load_lfsr", n_lfsr, 4'h2);
    check("nm_load_lock", n_lock, 1'b0);
    c_n.load = 1'b0; c_n.en = 1'b1;
    tick(); check("nm_s1_lfsr", n_lfsr, 4'h4);
    tick(); check("nm_s2_lfsr", n_lfsr, 4'h8);
    tick(); check("nm_zero_lfsr", n_lfsr, 4'h0);
    check("nm_zero_lock", n_lock, 1'b0);
    tick();
    check("nm_recover_lfsr", n_lfsr, 4'h1);
    check("nm_recover_lock", n_lock, 1'b1);
    check("nm_recover_wrap", n_wrap, 1'b0);
    tick();
    check("nm_after_lfsr", n_lfsr, 4'h3);
    check("nm_after_lock", n_lock, 1'b0);
    tick(); check("nm_7_lfsr", n_lfsr, 4'h7);
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("nm_stuck_lfsr_%0d", k), n_lfsr, 4'hF);
      check($sformatf("nm_stuck_wrap_%0d", k), n_wrap, 1'b0);
    end
    check("nm_period", n_period, 4'h0);
    check("nm_final_lock", n_lock, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
